// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmit and keyboard receive paths.
package ps2_pkg;

    // Host-to-device transfer sequencing.
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    // Common command bytes and the device acknowledge response.
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Falling edges that carry d0..d7 and parity; the next one releases DATA for the stop bit.
    localparam int unsigned FRAME_DATA_EDGES = 9;

    // PS/2 uses odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one PS/2 pad, rejects glitches shorter than FILT_LEN samples and
// strobes a one-cycle pulse on every accepted 1->0 transition.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          fall_q, fall_d;

    // Filter: count consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    // Two-flop synchronizer plus filter state; idle bus level is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value; the synchronizer depends on it.
            sync_q  <= {sync_q[0], line_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts out
// one 11-bit frame on device clock edges and reports ACK / timeout status.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000,
    parameter int FILT_LEN   = 8
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int INH_W       = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam int TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic       clk_level;
    logic       clk_fall;
    logic [1:0] data_sync_q;
    logic       data_sync;

    ps2_state_e       state_q, state_d;
    logic [8:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             rel_seen_q, rel_seen_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic             edge_ok;

    ps2_line_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_clk_filt (
        .clk_i   (CLK100MHZ),
        .rst_ni  (CPU_RESETN),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    // DATA only needs synchronizing; it is sampled while the device holds CLK low.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    assign data_sync = data_sync_q[1];

    // Our own inhibit pulls the filtered CLK low, so its echo edge must not count as
    // a device edge: accept edges only after CLK has been seen high since release.
    assign edge_ok = clk_fall & rel_seen_q;

    // Next-state and output logic; the timeout override comes last so it wins.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        rel_seen_d = rel_seen_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_d      = ack_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the old transfer.
                if (tx_start && !done_q) begin
                    shift_d   = {odd_parity(tx_data), tx_data};
                    ack_d     = 1'b0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
                    // Single registered handover: start bit asserted as CLK is released.
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b1;
                    bit_cnt_d  = '0;
                    to_cnt_d   = '0;
                    rel_seen_d = 1'b0;
                    state_d    = SEND;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            SEND: begin
                if (clk_level) begin
                    rel_seen_d = 1'b1;
                end
                if (edge_ok) begin
                    if (bit_cnt_q == 4'(FRAME_DATA_EDGES)) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            ACK: begin
                if (edge_ok) begin
                    ack_d   = ~data_sync;
                    state_d = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (clk_level && data_sync) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                timeout_d = 1'b1;
                ack_d     = 1'b0;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        end
    end

    // State, datapath and registered outputs; reset releases both lines at once.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            rel_seen_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rel_seen_q <= rel_seen_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_ok      = ack_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares sampled bits and status against a frame model built from the byte.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_HZ      = 1_000_000;
    localparam int INHIBIT_US  = 10;
    localparam int TIMEOUT_US  = 2000;
    localparam int FILT_LEN    = 8;
    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int HALF        = 25;

    typedef struct {
        logic [7:0] data;
        bit         clocked;
        bit         do_ack;
        bit         glitch;
        bit         restart;
        bit         start_on_done;
        bit         exp_ack;
        bit         exp_to;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, timeout;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk_in  = ~(ps2_clk_oe | bfm_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | bfm_data_low);

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILT_LEN   (FILT_LEN)
    ) dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ps2_clk_oe && ps2_data_oe) overlap_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame in transmission order: start 0, d0..d7, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = (b >> i) & 8'd1;
            ones += int'((b >> i) & 8'd1);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        logic [10:0] exp_bits;
        logic [10:0] got;
        int n;
        int d0;
        bit seen;
        exp_bits = model_frame(v.data);
        got = '0;
        d0 = done_cnt;

        tx_data = v.data;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check({tag, " busy at start"}, busy, 1);
        check({tag, " ack cleared"}, ack_ok, 0);
        check({tag, " timeout cleared"}, timeout, 0);
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            n++;
            tick();
        end
        check({tag, " inhibit cycles"}, n, INHIBIT_CYC);
        check({tag, " rts data_oe"}, ps2_data_oe, 1);

        if (!v.clocked) begin
            n = 0;
            seen = 0;
            while (n < TIMEOUT_CYC + 50 && !seen) begin
                tick();
                n++;
                if (done) seen = 1;
            end
            check({tag, " timeout latency"}, n, TIMEOUT_CYC);
        end else begin
            repeat (30) tick();
            got[0] = ~(ps2_data_oe | bfm_data_low);
            for (int e = 1; e <= 11; e++) begin
                if (e == 11 && v.do_ack) bfm_data_low = 1'b1;
                bfm_clk_low = 1'b1;
                for (int j = 0; j < HALF; j++) begin
                    tick();
                    if (v.restart && e == 3 && j == 15) begin
                        tx_data = CMD_RESET;
                        tx_start = 1'b1;
                    end else begin
                        tx_start = 1'b0;
                    end
                end
                bfm_clk_low = 1'b0;
                if (e <= 10) got[e] = ~(ps2_data_oe | bfm_data_low);
                if (e < 11) begin
                    for (int j = 0; j < HALF; j++) begin
                        tick();
                        if (v.glitch && e == 4 && j == 8)  bfm_clk_low = 1'b1;
                        if (v.glitch && e == 4 && j == 11) bfm_clk_low = 1'b0;
                    end
                end else begin
                    repeat (3) tick();
                    bfm_data_low = 1'b0;
                end
            end
            for (int i = 0; i < 11; i++) begin
                check($sformatf("%s bit%0d", tag, i), got[i], exp_bits[i]);
            end
            n = 0;
            seen = 0;
            while (n < 200 && !seen) begin
                tick();
                n++;
                if (done) seen = 1;
            end
        end

        check({tag, " done seen"}, seen, 1);
        check({tag, " busy falls with done"}, busy, 0);
        check({tag, " ack_ok"}, ack_ok, v.exp_ack);
        check({tag, " timeout"}, timeout, v.exp_to);
        check({tag, " clk_oe at done"}, ps2_clk_oe, 0);
        check({tag, " data_oe at done"}, ps2_data_oe, 0);
        if (v.start_on_done) tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check({tag, " done one cycle"}, done, 0);
        check({tag, " idle after done"}, busy, 0);
        repeat (20) tick();
        check({tag, " done count"}, done_cnt - d0, 1);
        check({tag, " still idle"}, ps2_clk_oe, 0);
        check({tag, " ack_ok holds"}, ack_ok, v.exp_ack);
        check({tag, " timeout holds"}, timeout, v.exp_to);
    endtask

    initial begin
        vec_t vecs [7];
        vec_t rv;
        int n;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) tick();
        check("reset clk_oe", ps2_clk_oe, 0);
        check("reset data_oe", ps2_data_oe, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset ack_ok", ack_ok, 0);
        check("reset timeout", timeout, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        for (int k = 0; k < 7; k++) begin
            run_frame(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset in the middle of a frame, after the fifth device edge.
        tx_data = 8'hA5;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            n++;
            tick();
        end
        repeat (30) tick();
        for (int e = 1; e <= 5; e++) begin
            bfm_clk_low = 1'b1;
            repeat (HALF) tick();
            if (e < 5) begin
                bfm_clk_low = 1'b0;
                repeat (HALF) tick();
            end
        end
        check("pre-reset busy", busy, 1);
        check("pre-reset data_oe (d4=0)", ps2_data_oe, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid reset clk_oe", ps2_clk_oe, 0);
        check("mid reset data_oe", ps2_data_oe, 0);
        check("mid reset busy", busy, 0);
        bfm_clk_low = 1'b0;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("no resume busy", busy, 0);
        check("no resume data_oe", ps2_data_oe, 0);
        rv = '{CMD_ECHO, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        run_frame(rv, "echo after reset");

        // Randomized bytes and ACK behaviour against the frame model.
        for (int r = 0; r < 6; r++) begin
            rv.data          = 8'($urandom_range(0, 255));
            rv.clocked       = 1'b1;
            rv.do_ack        = 1'($urandom_range(0, 1));
            rv.glitch        = 1'b0;
            rv.restart       = 1'b0;
            rv.start_on_done = 1'b0;
            rv.exp_ack       = rv.do_ack;
            rv.exp_to        = 1'b0;
            run_frame(rv, $sformatf("rnd%0d", r));
        end

        check("no oe overlap", overlap_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
